// File: rtl/piso_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : piso_serializer                                           |
// | Purpose  : Parallel-in / serial-out shifter with a valid/ready load  |
// |            port, frame_start / done markers and back-to-back frames. |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             r,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             done,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_shifted;
  logic [CW-1:0]    cnt;
  logic             head;
  logic             accept;

  // Bit order only changes which end of the captured word is the head and
  // which way the register moves.
  if (MSB_FIRST != 0) begin : g_msb_first
    assign head         = sreg[WIDTH-1];
    assign sreg_shifted = {sreg[WIDTH-2:0], 1'b0};
  end else begin : g_lsb_first
    assign head         = sreg[0];
    assign sreg_shifted = {1'b0, sreg[WIDTH-1:1]};
  end

  // A new word fits while idle or while the last bit is on the wire,
  // which is what allows frames to follow each other with no gap.
  assign load_ready = ~r & ((state == IDLE) | (cnt == '0));
  assign accept     = load_valid & load_ready;

  // The line is held low whenever no frame bit is being presented.
  assign sout = sout_valid & head;

  // Frame sequencing: capture, shift out WIDTH bits, then idle or restart.
  always_ff @(posedge clk) begin
    if (r) begin
      state       <= IDLE;
      sreg        <= '0;
      cnt         <= '0;
      sout_valid  <= 1'b0;
      frame_start <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
    end else if (accept) begin
      state       <= SHIFT;
      sreg        <= din;
      cnt         <= CW'(WIDTH - 1);
      sout_valid  <= 1'b1;
      frame_start <= 1'b1;
      done        <= 1'b0;
      busy        <= 1'b1;
    end else if (state == SHIFT) begin
      if (cnt == '0) begin
        state       <= IDLE;
        sreg        <= '0;
        sout_valid  <= 1'b0;
        frame_start <= 1'b0;
        done        <= 1'b0;
        busy        <= 1'b0;
      end else begin
        sreg        <= sreg_shifted;
        cnt         <= cnt - CW'(1);
        frame_start <= 1'b0;
        // The bit about to be presented is the last one when cnt reaches 0.
        done        <= (cnt == CW'(1));
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the parallel word width in bits, legal range 2..16.
REQ-002 SHALL have parameter MSB_FIRST, default 1, where 1 means bit WIDTH-1 is sent first and 0 means bit 0 is sent first.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port r  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port din  input  WIDTH  parallel word to serialize.
REQ-006 SHALL have port load_valid  input  1  upstream offers din this cycle.
REQ-007 SHALL have port load_ready  output  1  block accepts din this cycle.
REQ-008 SHALL have port sout  output  1  serial data bit, feeding the downstream SIPO d input.
REQ-009 SHALL have port sout_valid  output  1  sout carries a frame bit this cycle.
REQ-010 SHALL have port frame_start  output  1  pulse marking the first bit of each frame.
REQ-011 SHALL have port done  output  1  pulse marking the last bit of each frame.
REQ-012 SHALL have port busy  output  1  a frame is being shifted out.

Function
REQ-013 SHALL implement the states IDLE and SHIFT, plus a bit counter of ceil(log2(WIDTH)) bits.
REQ-014 SHALL drive load_ready combinationally: 1 in IDLE, 1 in SHIFT when counter==0, otherwise 0, and 0 whenever r=1.
REQ-015 SHALL accept a word on a rising edge where load_valid=1 and load_ready=1: capture din into the shift register, set counter=WIDTH-1, enter SHIFT.
REQ-016 SHALL present the first bit of an accepted word in the cycle immediately after acceptance, giving 1-cycle latency.
REQ-017 SHALL in SHIFT drive sout_valid=1 and sout = current head bit (MSB if MSB_FIRST=1, else LSB), then shift by one and decrement the counter on each edge.
REQ-018 SHALL assert frame_start only in the cycle carrying bit index 0 of a frame.
REQ-019 SHALL assert done only in the cycle carrying the final bit, where counter==0.
REQ-020 SHALL hold busy=1 for exactly the WIDTH cycles of each frame and 0 otherwise.
REQ-021 SHALL, on the final-bit edge, enter IDLE if no word is accepted, or start the new frame with no gap cycle if a word is accepted (back-to-back).
REQ-022 SHALL ignore load_valid while load_ready=0: no buffering, din not sampled, and the frame in progress is unaffected.
REQ-023 SHALL ignore din changes during SHIFT, since bits come only from the captured copy.
REQ-024 SHALL force sout=0 whenever sout_valid=0.
REQ-025 SHALL sustain a throughput of one word per WIDTH cycles under continuous load_valid.

Reset
REQ-026 SHALL, on an edge where r=1, enter IDLE, clear the shift register and counter, and drive sout, sout_valid, frame_start, done and busy to 0 from the next cycle.
REQ-027 SHALL give r priority over load_valid on the same edge: the word is not accepted.
REQ-028 SHALL, on r asserted mid-frame, abort the frame without asserting done, emit no further bits, and accept a new load normally after r deasserts.

Verification (WIDTH=4 unless stated)
REQ-029 SHALL cover: reset, then din=1011 with load_valid pulsed 1 cycle -> sout 1,0,1,1 on the next 4 cycles, sout_valid and busy 1 for those 4, frame_start on bit 1, done on bit 4, IDLE after.
REQ-030 SHALL cover: load_valid held with din=1011 then 0110 -> 8 contiguous valid bits 1,0,1,1,0,1,1,0, frame_start on cycles 1 and 5, done on cycles 4 and 8, no gap.
REQ-031 SHALL cover: load_valid=1 with din=1111 during bits 1-3 of frame 1011 -> load_ready=0, sout stream unchanged 1,0,1,1.
REQ-032 SHALL cover: r=1 during bit 2 of frame 1011 -> next cycle all outputs 0, no done; next load of 0101 yields 0,1,0,1.
REQ-033 SHALL cover: MSB_FIRST=0 with din=1011 -> sout 1,1,0,1.
REQ-034 SHALL cover: r=1 and load_valid=1 on the same edge -> no frame starts, sout_valid stays 0.
